// File: rtl/accumulator_64_bit_pkg.sv
// Shared encodings and widths for the streaming 64-bit accumulator.
package accumulator_64_bit_pkg;

    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_64_bit.sv
// 64-bit ripple-carry adder: per-bit full adders chained through the carry vector.
module full_adder_64_bit
    import accumulator_64_bit_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    logic [DATA_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[DATA_W];

endmodule

// File: rtl/accumulator_64_bit.sv
// Burst add/subtract accumulator: folds operand beats into a running sum and
// presents sum, sticky carry/overflow and a saturating beat count on a result port.
module accumulator_64_bit
    import accumulator_64_bit_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sub,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_carry,
    output logic              out_ovf,
    output logic [CNT_W-1:0]  out_count
);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] acc;
    logic              carry, ovf;
    logic [CNT_W-1:0]  count;

    logic [DATA_W-1:0] add_b, add_sum;
    logic              add_cout;
    logic              beat;

    assign in_ready  = (state == ST_ACC);
    assign out_valid = (state == ST_DONE);
    assign beat      = in_ready & in_valid;

    // Subtraction is acc + ~in_data + 1, so cout=0 signals a borrow.
    assign add_b = in_sub ? ~in_data : in_data;

    full_adder_64_bit u_add (
        .a    (acc),
        .b    (add_b),
        .cin  (in_sub),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)          state_nxt = ST_ACC;
            ST_ACC:  if (beat && in_last) state_nxt = ST_DONE;
            ST_DONE: if (out_ready)      state_nxt = ST_IDLE;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || (state == ST_IDLE && start)) begin
            acc   <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
            count <= '0;
        end else if (beat) begin
            acc   <= add_sum;
            carry <= carry | (in_sub ? ~add_cout : add_cout);
            ovf   <= ovf | ((acc[DATA_W-1] == add_b[DATA_W-1]) &
                            (add_sum[DATA_W-1] != acc[DATA_W-1]));
            count <= (count == {CNT_W{1'b1}}) ? count : count + 1'b1;
        end
    end

    assign out_sum   = acc;
    assign out_carry = carry;
    assign out_ovf   = ovf;
    assign out_count = count;

endmodule
